sccb_config_ov7670: RTL and testbench

//  Configures the OV7670 over SCCB (3-phase write only) before interface_OV7670 captures frames.
//  - On iniciar, writes a fixed internal table of N_REGS {reg,val} pairs, one transaction per entry.
//  - Raises pronto when the table is done. The capture FSM starts only after pronto.

---
 rtl/sccb_config_ov7670_pkg.sv | 33 +++
 rtl/sccb_config_ov7670_escrita.sv | 127 ++++++++++++
 rtl/sccb_config_ov7670.sv | 171 +++++++++++++++++
 tb/tb_sccb_config_ov7670.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sccb_config_ov7670_pkg.sv
// OV7670 register addresses, SCCB write ID and FSM state codes shared with the hexa7seg displays.
// No logic; constants and types only.
// Not applicable.
package sccb_config_ov7670_pkg;

    localparam logic [7:0] OV_DEVICE_ADDR = 8'h42;

    localparam logic [7:0] REG_CLKRC = 8'h11;
    localparam logic [7:0] REG_COM7  = 8'h12;
    localparam logic [7:0] REG_COM3  = 8'h0C;
    localparam logic [7:0] REG_COM14 = 8'h3E;
    localparam logic [7:0] REG_COM15 = 8'h40;
    localparam logic [7:0] REG_TSLB  = 8'h3A;

    localparam logic [7:0] COM7_RESET = 8'h80;

    typedef enum logic [3:0] {
        ST_OCIOSO     = 4'd0,
        ST_CARREGA    = 4'd1,
        ST_START      = 4'd2,
        ST_BIT        = 4'd3,
        ST_STOP       = 4'd4,
        ST_ESPERA     = 4'd5,
        ST_FIM        = 4'd6,
        ST_ESPERA_RST = 4'd7
    } estado_t;

    typedef struct packed {
        logic [7:0] endereco;
        logic [7:0] valor;
    } reg_par_t;

endpackage

// File: rtl/sccb_config_ov7670_escrita.sv
// One SCCB 3-phase write (START, 27 bits, STOP) plus the quarter-bit tick generator.
// Latency: 2+108+3 ticks from inicia to pronto_tx; first tick DIV clocks after limpa drops.
// No backpressure: inicia is honoured only while idle, pronto_tx is a 1-cycle pulse.
module sccb_escrita_3fases
    import sccb_config_ov7670_pkg::*;
#(
    parameter int DIV = 125
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        limpa,
    input  logic        inicia,
    input  logic [23:0] dado,
    output logic        tick,
    output logic        pronto_tx,
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    output estado_t     fase
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] cnt;
    logic [1:0]    quarto;
    logic [3:0]    pos;
    logic [1:0]    nbyte;
    logic [23:0]   sr;

    assign tick      = !limpa && (cnt == DW'(DIV - 1));
    assign pronto_tx = (fase == ST_STOP) && tick && (quarto == 2'd2);

    always_ff @(posedge clock) begin
        if (reset || limpa || tick) cnt <= '0;
        else                        cnt <= cnt + DW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fase     <= ST_OCIOSO;
            sioc     <= 1'b1;
            siod_out <= 1'b1;
            siod_oe  <= 1'b0;
            quarto   <= 2'd0;
            pos      <= 4'd0;
            nbyte    <= 2'd0;
            sr       <= 24'd0;
        end else begin
            case (fase)
                ST_OCIOSO: begin
                    if (inicia) begin
                        sr     <= dado;
                        quarto <= 2'd0;
                        fase   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (quarto == 2'd0) begin
                            siod_oe  <= 1'b1;
                            siod_out <= 1'b0;
                            quarto   <= 2'd1;
                        end else begin
                            sioc   <= 1'b0;
                            quarto <= 2'd0;
                            pos    <= 4'd0;
                            nbyte  <= 2'd0;
                            fase   <= ST_BIT;
                        end
                    end
                end
                ST_BIT: begin
                    if (tick) begin
                        quarto <= quarto + 2'd1;
                        case (quarto)
                            2'd0: begin
                                // 9th bit of each phase: release the line, ACK is ignored
                                if (pos == 4'd8) begin
                                    siod_oe <= 1'b0;
                                end else begin
                                    siod_oe  <= 1'b1;
                                    siod_out <= sr[23];
                                    sr       <= {sr[22:0], 1'b0};
                                end
                            end
                            2'd1: sioc <= 1'b1;
                            2'd2: ;
                            2'd3: begin
                                sioc <= 1'b0;
                                if (pos == 4'd8) begin
                                    pos <= 4'd0;
                                    if (nbyte == 2'd2) fase <= ST_STOP;
                                    else               nbyte <= nbyte + 2'd1;
                                end else begin
                                    pos <= pos + 4'd1;
                                end
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        case (quarto)
                            2'd0: begin
                                siod_oe  <= 1'b1;
                                siod_out <= 1'b0;
                                quarto   <= 2'd1;
                            end
                            2'd1: begin
                                sioc   <= 1'b1;
                                quarto <= 2'd2;
                            end
                            default: begin
                                siod_oe  <= 1'b0;
                                siod_out <= 1'b1;
                                quarto   <= 2'd0;
                                fase     <= ST_OCIOSO;
                            end
                        endcase
                    end
                end
                default: fase <= ST_OCIOSO;
            endcase
        end
    end

endmodule

// File: rtl/sccb_config_ov7670.sv
// OV7670 SCCB configurator: writes the fixed register table on an iniciar edge, then raises pronto.
// Latency: N_REGS*(1 + 113 + GAP_TICKS ticks); OV7670_SOFT_RESET_EN adds a COM7 reset write + 1 ms wait.
// No backpressure: start edges arriving while ocupado=1 are dropped.
module sccb_config_ov7670
    import sccb_config_ov7670_pkg::*;
#(
    parameter int         CLK_HZ      = 50_000_000,
    parameter int         SCCB_HZ     = 100_000,
    parameter logic [7:0] DEVICE_ADDR = OV_DEVICE_ADDR,
    parameter int         N_REGS      = 16,
    parameter int         GAP_TICKS   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    output logic       ocupado,
    output logic       pronto,
    output logic [7:0] db_indice,
    output logic [3:0] db_estado
);

    localparam int DIV_RAW = CLK_HZ / (4 * SCCB_HZ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int IW      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int GW      = $clog2(GAP_TICKS + 1);

    estado_t     estado;
    estado_t     fase_tx;
    logic [IW-1:0] indice;
    logic [GW-1:0] gap_cnt;
    logic        iniciar_d;
    logic        tick;
    logic        pronto_tx;
    logic        inicia_tx;
    logic [23:0] dado_tx;
    reg_par_t    par;

`ifdef OV7670_SOFT_RESET_EN
    localparam int RESET_WAIT = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int RW         = $clog2(RESET_WAIT + 1);
    logic          prologo;
    logic [RW-1:0] espera_cnt;
`endif

    always_comb begin
        par = {8'hFF, 8'hFF};
        case (8'(indice))
            8'd0:  par = {REG_COM7,  COM7_RESET};
            8'd1:  par = {REG_CLKRC, 8'h01};
            8'd2:  par = {REG_COM15, 8'hD0};
            8'd3:  par = {REG_COM7,  8'h04};
            8'd4:  par = {REG_COM3,  8'h00};
            8'd5:  par = {REG_COM14, 8'h00};
            8'd6:  par = {8'h8C,     8'h00};
            8'd7:  par = {8'h04,     8'h00};
            8'd8:  par = {REG_TSLB,  8'h04};
            8'd9:  par = {8'h14,     8'h18};
            8'd10: par = {8'h4F,     8'hB3};
            8'd11: par = {8'h50,     8'hB3};
            8'd12: par = {8'h51,     8'h00};
            8'd13: par = {8'h52,     8'h3D};
            8'd14: par = {8'h53,     8'hA7};
            8'd15: par = {8'h54,     8'hE4};
            default: par = {8'hFF, 8'hFF};
        endcase
    end

    always_comb begin
        dado_tx = {DEVICE_ADDR, par.endereco, par.valor};
`ifdef OV7670_SOFT_RESET_EN
        if (prologo) dado_tx = {DEVICE_ADDR, REG_COM7, COM7_RESET};
`endif
    end

    assign inicia_tx = (estado == ST_CARREGA);

    sccb_escrita_3fases #(.DIV(DIV)) u_escrita (
        .clock     (clock),
        .reset     (reset),
        .limpa     (estado == ST_OCIOSO),
        .inicia    (inicia_tx),
        .dado      (dado_tx),
        .tick      (tick),
        .pronto_tx (pronto_tx),
        .sioc      (sioc),
        .siod_out  (siod_out),
        .siod_oe   (siod_oe),
        .fase      (fase_tx)
    );

    // ST_START here means "write in flight"; the display shows the writer's own phase instead
    assign db_estado = (estado == ST_START) ? fase_tx : estado;
    assign db_indice = 8'(indice);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= ST_OCIOSO;
            indice     <= '0;
            gap_cnt    <= '0;
            iniciar_d  <= 1'b0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
`ifdef OV7670_SOFT_RESET_EN
            prologo    <= 1'b0;
            espera_cnt <= '0;
`endif
        end else begin
            iniciar_d <= iniciar;
            case (estado)
                ST_OCIOSO: begin
                    if (iniciar && !iniciar_d) begin
                        pronto  <= 1'b0;
                        ocupado <= 1'b1;
                        indice  <= '0;
                        gap_cnt <= '0;
                        estado  <= ST_CARREGA;
`ifdef OV7670_SOFT_RESET_EN
                        prologo <= 1'b1;
`endif
                    end
                end
                ST_CARREGA: estado <= ST_START;
                ST_START: begin
                    if (pronto_tx) begin
                        gap_cnt <= '0;
`ifdef OV7670_SOFT_RESET_EN
                        if (prologo) begin
                            espera_cnt <= '0;
                            estado     <= ST_ESPERA_RST;
                        end else
`endif
                        estado <= ST_ESPERA;
                    end
                end
                ST_ESPERA: begin
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_TICKS - 1)) begin
                            gap_cnt <= '0;
                            if (indice == IW'(N_REGS - 1)) begin
                                pronto  <= 1'b1;
                                ocupado <= 1'b0;
                                estado  <= ST_FIM;
                            end else begin
                                indice <= indice + IW'(1);
                                estado <= ST_CARREGA;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                ST_FIM: estado <= ST_OCIOSO;
`ifdef OV7670_SOFT_RESET_EN
                ST_ESPERA_RST: begin
                    if (espera_cnt == RW'(RESET_WAIT - 1)) begin
                        prologo <= 1'b0;
                        estado  <= ST_CARREGA;
                    end else begin
                        espera_cnt <= espera_cnt + RW'(1);
                    end
                end
`endif
                default: estado <= ST_OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_config_ov7670.sv
// Directed bench for sccb_config_ov7670 with DIV=1 and a 3-entry table; an SCCB monitor decodes writes.
module tb_sccb_config_ov7670;

    localparam int RESET_WAIT = 400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       sioc, siod_out, siod_oe, ocupado, pronto;
    logic [7:0] db_indice;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    sccb_config_ov7670 #(
        .CLK_HZ  (400_000),
        .SCCB_HZ (100_000),
        .N_REGS  (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .sioc      (sioc),
        .siod_out  (siod_out),
        .siod_oe   (siod_oe),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_indice (db_indice),
        .db_estado (db_estado)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // SCCB line monitor
    logic        p_sioc = 1'b1;
    logic        p_line = 1'b1;
    logic        mon_line;
    bit          in_frame = 0;
    int          bitcnt = 0;
    logic [26:0] sh = '0;
    int          viol = 0;
    int          ackviol = 0;
    int          cyc_cnt = 0;
    logic [23:0] words[$];
    int          starts[$];
    int          stops[$];

    initial forever begin
        @(negedge clock);
        cyc_cnt++;
        mon_line = siod_oe ? siod_out : 1'b1;
        if (reset) begin
            in_frame = 0;
        end else if (sioc !== p_sioc && mon_line !== p_line) begin
            viol++;
        end else if (sioc && p_sioc && mon_line !== p_line) begin
            if (!mon_line) begin
                if (in_frame) viol++;
                in_frame = 1;
                bitcnt   = 0;
                starts.push_back(cyc_cnt);
            end else begin
                if (!in_frame || bitcnt != 27) viol++;
                else begin
                    words.push_back({sh[26:19], sh[17:10], sh[8:1]});
                    stops.push_back(cyc_cnt);
                end
                in_frame = 0;
            end
        end else if (sioc && !p_sioc && in_frame && bitcnt < 27) begin
            if (bitcnt % 9 == 8 && siod_oe) ackviol++;
            sh = {sh[25:0], mon_line};
            bitcnt++;
        end
        p_sioc = sioc;
        p_line = mon_line;
    end

    initial begin
        logic [23:0] exp_words[$];
        int  n;
        bit  seen;
        logic prev_ocup;

`ifdef OV7670_SOFT_RESET_EN
        exp_words.push_back(24'h421280);
`endif
        exp_words.push_back(24'h421280);
        exp_words.push_back(24'h421101);
        exp_words.push_back(24'h4240D0);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("rst_sioc",    32'(sioc), 1);
        check("rst_siod_oe", 32'(siod_oe), 0);
        check("rst_pronto",  32'(pronto), 0);
        check("rst_ocupado", 32'(ocupado), 0);
        check("rst_estado",  32'(db_estado), 0);
        check("rst_indice",  32'(db_indice), 0);
        check("idle_writes", words.size(), 0);

        // full run with a second iniciar pulse mid-run
        iniciar   = 1'b1;
        n         = 0;
        seen      = 0;
        prev_ocup = 1'b0;
        while (!seen && n < 5000) begin
            prev_ocup = ocupado;
            @(posedge clock);
            #1;
            n++;
            if (n == 1) begin
                iniciar = 1'b0;
                check("run_ocupado", 32'(ocupado), 1);
                check("run_carrega", 32'(db_estado), 1);
            end
            if (n == 2) check("run_start", 32'(db_estado), 2);
            if (n == 150) iniciar = 1'b1;
            if (n == 151) iniciar = 1'b0;
`ifndef OV7670_SOFT_RESET_EN
            if (n == 120) begin
                check("gap_estado", 32'(db_estado), 5);
                check("gap_indice", 32'(db_indice), 0);
            end
            if (n == 200) begin
                check("e1_estado", 32'(db_estado), 3);
                check("e1_indice", 32'(db_indice), 1);
            end
            if (n == 300) begin
                check("e2_estado", 32'(db_estado), 3);
                check("e2_indice", 32'(db_indice), 2);
            end
`endif
            seen = pronto;
        end
        check("pronto_seen", 32'(seen), 1);
        check("ocupado_fall", 32'(ocupado), 0);
        check("ocupado_before", 32'(prev_ocup), 1);
`ifndef OV7670_SOFT_RESET_EN
        check("pronto_latency", n - 1, 3 * (2 + 108 + 3 + 8) + 3);
`endif
        repeat (50) @(posedge clock);
        #1;
        check("pronto_held", 32'(pronto), 1);
        check("end_estado",  32'(db_estado), 0);
        check("end_indice",  32'(db_indice), 2);
        check("nwrites",     words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size(); i++)
            if (i < words.size()) check($sformatf("word%0d", i), 32'(words[i]), 32'(exp_words[i]));
        check("protocol", viol, 0);
        check("ack_release", ackviol, 0);
`ifdef OV7670_SOFT_RESET_EN
        if (starts.size() >= 2 && stops.size() >= 1)
            check("reset_wait", 32'(starts[1] - stops[0] >= RESET_WAIT), 1);
        else
            check("reset_wait_frames", starts.size(), 2);
`endif

        // reset at the 50th bit tick of a run
        words.delete();
        starts.delete();
        stops.delete();
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        n = 0;
        while (db_estado !== 4'd3 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("bit_reached", 32'(db_estado), 3);
        repeat (49) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_siod_oe", 32'(siod_oe), 0);
        check("abort_sioc",    32'(sioc), 1);
        check("abort_estado",  32'(db_estado), 0);
        check("abort_pronto",  32'(pronto), 0);
        check("abort_ocupado", 32'(ocupado), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        check("abort_writes", words.size(), 0);

        // rerun after abort
        repeat (5) @(posedge clock);
        #1 iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        n = 0;
        while (!pronto && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("rerun_pronto", 32'(pronto), 1);
        check("rerun_nwrites", words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size(); i++)
            if (i < words.size()) check($sformatf("rerun_word%0d", i), 32'(words[i]), 32'(exp_words[i]));
        check("rerun_protocol", viol, 0);
        check("rerun_ack", ackviol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
